// File: rtl/sklansky_mp_adder.sv
// Multi-precision adder: streams 16-bit word pairs (LSW first) through one Sklansky prefix core.
// Optional subtract mode is enabled by defining MPADD_SUB_EN (adds the in_sub port).

module sklansky (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  always_comb begin
    logic [15:0] g, p, gn, pn, p0;
    p0 = a ^ b;
    g  = a & b;
    p  = p0;
    // Folding cin into bit 0's generate makes every group carry include it.
    g[0] = g[0] | (p0[0] & cin);
    for (int l = 0; l < 4; l++) begin
      gn = g;
      pn = p;
      for (int i = 0; i < 16; i++) begin
        if (((i >> l) & 1) != 0) begin
          gn[4'(i)] = g[4'(i)] | (p[4'(i)] & g[4'(((i >> l) << l) - 1)]);
          pn[4'(i)] = p[4'(i)] & p[4'(((i >> l) << l) - 1)];
        end
      end
      g = gn;
      p = pn;
    end
    sum  = p0 ^ {g[14:0], cin};
    cout = g[15];
  end
endmodule

module sklansky_mp_adder #(
  parameter int MAX_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cin_init,
`ifdef MPADD_SUB_EN
  input  logic        in_sub,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_last,
  output logic        out_cout,
  output logic        out_len_err,
  output logic        busy
);
  localparam int CW = $clog2(MAX_WORDS) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   word_cnt, cnt_nxt;
  logic            carry_q, carry_nxt;
  logic            last_nxt, cout_nxt, len_err_nxt;
  logic            xfer_in;
  logic [15:0]     add_b, add_sum;
  logic            add_cin, add_cout;

  assign in_ready = !out_valid || out_ready;
  assign xfer_in  = in_valid && in_ready;
  assign busy     = (state == RUN);

`ifdef MPADD_SUB_EN
  logic sub_q, sub_eff;

  // The mode bit is taken from the port on word 0 and from the register afterwards.
  assign sub_eff = (state == IDLE) ? in_sub : sub_q;
  assign add_b   = sub_eff ? ~in_b : in_b;
  assign add_cin = (state == IDLE) ? (in_sub | cin_init) : carry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sub_q <= 1'b0;
    else if (xfer_in && state == IDLE)
      sub_q <= in_sub;
  end
`else
  assign add_b   = in_b;
  assign add_cin = (state == IDLE) ? cin_init : carry_q;
`endif

  sklansky u_core (
    .a    (in_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = word_cnt;
    carry_nxt   = carry_q;
    last_nxt    = 1'b0;
    cout_nxt    = 1'b0;
    len_err_nxt = 1'b0;
    if (xfer_in) begin
      carry_nxt = add_cout;
      case (state)
        IDLE: begin
          if (in_last) begin
            last_nxt  = 1'b1;
            cout_nxt  = add_cout;
            carry_nxt = 1'b0;
            cnt_nxt   = '0;
          end else begin
            state_nxt = RUN;
            cnt_nxt   = CW'(1);
          end
        end
        RUN: begin
          if (in_last || word_cnt == CW'(MAX_WORDS - 1)) begin
            last_nxt    = 1'b1;
            cout_nxt    = add_cout;
            len_err_nxt = !in_last;
            carry_nxt   = 1'b0;
            cnt_nxt     = '0;
            state_nxt   = IDLE;
          end else begin
            cnt_nxt = word_cnt + CW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      word_cnt    <= '0;
      carry_q     <= 1'b0;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_last    <= 1'b0;
      out_cout    <= 1'b0;
      out_len_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      word_cnt <= cnt_nxt;
      carry_q  <= carry_nxt;
      // Output register loads on accept; otherwise drains once the consumer takes it.
      if (xfer_in) begin
        out_valid   <= 1'b1;
        out_sum     <= add_sum;
        out_last    <= last_nxt;
        out_cout    <= cout_nxt;
        out_len_err <= len_err_nxt;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sklansky_mp_adder.sv
// Directed-vector bench for sklansky_mp_adder; subtract vectors run when MPADD_SUB_EN is defined.

module tb_sklansky_mp_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        cin_init;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_last;
  logic        out_cout;
  logic        out_len_err;
  logic        busy;
`ifdef MPADD_SUB_EN
  logic        in_sub;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sklansky_mp_adder #(.MAX_WORDS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cin_init    (cin_init),
`ifdef MPADD_SUB_EN
    .in_sub      (in_sub),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_last    (out_last),
    .out_cout    (out_cout),
    .out_len_err (out_len_err),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Presents one word, lets one edge accept it, and returns 1 ns after that edge.
  task automatic xfer(input logic [15:0] a, input logic [15:0] b, input logic last, input logic cin);
    in_a     = a;
    in_b     = b;
    in_last  = last;
    cin_init = cin;
    in_valid = 1'b1;
    #1;
    check("in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [15:0] sum, input logic last,
                           input logic cout, input logic err);
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".sum"}, out_sum, sum);
    check({tag, ".last"}, out_last, last);
    check({tag, ".cout"}, out_cout, cout);
    check({tag, ".len_err"}, out_len_err, err);
  endtask

  initial begin
    rst       = 1'b1;
    cin_init  = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
`ifdef MPADD_SUB_EN
    in_sub    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", out_valid, 0);
    check("rst.sum", out_sum, 0);
    check("rst.last", out_last, 0);
    check("rst.cout", out_cout, 0);
    check("rst.len_err", out_len_err, 0);
    check("rst.busy", busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single word
    xfer(16'd345, 16'd134, 1'b1, 1'b0);
    check_out("t1", 16'd479, 1'b1, 1'b0, 1'b0);
    check("t1.busy", busy, 0);

    // Carry crossing a word boundary
    xfer(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check_out("t2w0", 16'h0000, 1'b0, 1'b0, 1'b0);
    check("t2.busy", busy, 1);
    xfer(16'h0001, 16'h0000, 1'b1, 1'b0);
    check_out("t2w1", 16'h0002, 1'b1, 1'b0, 1'b0);
    check("t2.idle", busy, 0);

    // Final carry, then no leak into the next operation
    xfer(16'hFFFF, 16'h0001, 1'b1, 1'b0);
    check_out("t3a", 16'h0000, 1'b1, 1'b1, 1'b0);
    xfer(16'd4567, 16'd234, 1'b1, 1'b1);
    check_out("t3b", 16'd4802, 1'b1, 1'b0, 1'b0);

    // Backpressure on a 4-word operation
    xfer(16'h1000, 16'h2000, 1'b0, 1'b0);
    check_out("t4w0", 16'h3000, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_a      = 16'hFFFF;
    in_b      = 16'h0001;
    in_last   = 1'b0;
    in_valid  = 1'b1;
    #1;
    check("t4.stall_ready", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("t4.stall_ready", in_ready, 0);
      check("t4.stall_sum", out_sum, 16'h3000);
      check("t4.stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_out("t4w1", 16'h0000, 1'b0, 1'b0, 1'b0);
    xfer(16'h0010, 16'h0020, 1'b0, 1'b0);
    check_out("t4w2", 16'h0031, 1'b0, 1'b0, 1'b0);
    xfer(16'h8000, 16'h8000, 1'b1, 1'b0);
    check_out("t4w3", 16'h0000, 1'b1, 1'b1, 1'b0);

    // Forced termination after 8 words; word 7 produces a carry that must not leak
    for (int i = 0; i < 7; i++) begin
      xfer(16'h0100 + 16'(i), 16'h0000, 1'b0, 1'b0);
      check_out("t5w", 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0);
    end
    xfer(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check_out("t5w7", 16'h0000, 1'b1, 1'b1, 1'b1);
    check("t5.idle", busy, 0);
    xfer(16'd5, 16'd5, 1'b0, 1'b0);
    check_out("t5w8", 16'd10, 1'b0, 1'b0, 1'b0);
    check("t5.newop", busy, 1);

    // Asynchronous reset mid-operation
    xfer(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t5.rst_valid", out_valid, 0);
    check("t5.rst_busy", busy, 0);
    check("t5.rst_sum", out_sum, 0);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    xfer(16'd10, 16'd20, 1'b1, 1'b1);
    check_out("t5post", 16'd31, 1'b1, 1'b0, 1'b0);

`ifdef MPADD_SUB_EN
    in_sub = 1'b1;
    xfer(16'd6409, 16'd23, 1'b1, 1'b0);
    check_out("t6a", 16'd6386, 1'b1, 1'b1, 1'b0);
    xfer(16'd23, 16'd6409, 1'b1, 1'b0);
    check_out("t6b", 16'hE70E, 1'b1, 1'b0, 1'b0);
    in_sub = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end
endmodule
